// File: rtl/seq_shift_add_multiplier_pkg.sv
// seq_mul_pkg: shared types and sizing helpers
// for the sequential shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // bit counter must hold WIDTH-1
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // carry bit + upper half + lower half
  function automatic int acc_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// seq_shift_add_multiplier_if: start/done handshake
// and operand/result bus of the multiplier.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);

  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/seq_shift_add_multiplier_datapath.sv
// seq_mul_datapath: accumulator, add/shift step,
// operand magnitude and final sign correction.
module seq_mul_datapath
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               fin,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  localparam int AW = acc_width(WIDTH);

  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] mag_a;
  logic             neg;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [WIDTH:0]   upper;

  // most negative value wraps to 2^(WIDTH-1), still exact unsigned
  assign mag_a_in = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign mag_b_in = (signed_mode && b[WIDTH-1]) ? -b : b;

  // conditional add into the upper part, carry lands in the top bit
  always_comb begin
    upper = acc[AW-1:WIDTH];
    if (acc[0]) begin
      upper = acc[AW-1:WIDTH] + {1'b0, mag_a};
    end
  end

  // load operands, then add+shift each RUN cycle, then sign-correct
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      mag_a   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      if (load) begin
        acc   <= {{(WIDTH+1){1'b0}}, mag_b_in};
        mag_a <= mag_a_in;
        neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (step) begin
        acc <= {1'b0, upper, acc[WIDTH-1:1]};
      end
      if (fin) begin
        product <= neg ? -acc[2*WIDTH-1:0]
                       : acc[2*WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: control FSM, bit counter
// and handshake around the shift-add datapath.
module seq_shift_add_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                       clk,
  input logic                       reset,
  seq_shift_add_multiplier_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;

  // start only counts while not busy
  assign accept = bus.start &&
                  ((state == IDLE) || (state == DONE));

  // sequencing with registered busy/done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= RUN;
            cnt      <= CW'(WIDTH - 1);
            bus.busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          state    <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  seq_mul_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .step       (state == RUN),
    .fin        (state == SIGN),
    .signed_mode(bus.signed_mode),
    .a          (bus.a),
    .b          (bus.b),
    .product    (bus.product)
  );

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: random + directed bench
// with a cycle-level arithmetic reference model.
module tb_seq_shift_add_multiplier;

  localparam int WS [3] = '{4, 8, 16};

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        st [3];
  logic        sm [3];
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic        bz [3];
  logic        dn [3];
  logic [63:0] pr [3];

  int m_cnt [3];
  logic m_done [3];
  longint m_prod [3];
  longint m_pend [3];

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  seq_shift_add_multiplier_if #(.WIDTH(4))  i4 ();
  seq_shift_add_multiplier_if #(.WIDTH(8))  i8 ();
  seq_shift_add_multiplier_if #(.WIDTH(16)) i16 ();

  seq_shift_add_multiplier #(.WIDTH(4))
    u4 (.clk(clk), .reset(reset), .bus(i4));
  seq_shift_add_multiplier #(.WIDTH(8))
    u8 (.clk(clk), .reset(reset), .bus(i8));
  seq_shift_add_multiplier #(.WIDTH(16))
    u16 (.clk(clk), .reset(reset), .bus(i16));

  assign i4.start = st[0];
  assign i4.signed_mode = sm[0];
  assign i4.a = av[0][3:0];
  assign i4.b = bv[0][3:0];
  assign bz[0] = i4.busy;
  assign dn[0] = i4.done;
  assign pr[0] = 64'(i4.product);

  assign i8.start = st[1];
  assign i8.signed_mode = sm[1];
  assign i8.a = av[1][7:0];
  assign i8.b = bv[1][7:0];
  assign bz[1] = i8.busy;
  assign dn[1] = i8.done;
  assign pr[1] = 64'(i8.product);

  assign i16.start = st[2];
  assign i16.signed_mode = sm[2];
  assign i16.a = av[2][15:0];
  assign i16.b = bv[2][15:0];
  assign bz[2] = i16.busy;
  assign dn[2] = i16.done;
  assign pr[2] = 64'(i16.product);

  always #5 clk = ~clk;

  function automatic longint sval(int w, bit s, longint x);
    longint v;
    v = x & ((64'sd1 <<< w) - 1);
    if (s && ((v >>> (w - 1)) & 1) == 1)
      v = v - (64'sd1 <<< w);
    return v;
  endfunction

  function automatic longint ref_mul(int w, bit s,
                                     longint x, longint y);
    longint p;
    p = sval(w, s, x) * sval(w, s, y);
    return p & ((64'sd1 <<< (2 * w)) - 1);
  endfunction

  task automatic chk(string nm, int w, longint got,
                     longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s w=%0d got=%0h want=%0h",
                  nm, w, got, exp);
  endtask

  // reference: accept when idle, busy W+1 cycles, then done
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i]  <= 0;
        m_done[i] <= 1'b0;
        m_prod[i] <= 0;
      end else if (m_cnt[i] > 0) begin
        m_cnt[i]  <= m_cnt[i] - 1;
        m_done[i] <= (m_cnt[i] == 1);
        if (m_cnt[i] == 1) m_prod[i] <= m_pend[i];
      end else begin
        m_done[i] <= 1'b0;
        if (st[i]) begin
          m_cnt[i]  <= WS[i] + 1;
          m_pend[i] <= ref_mul(WS[i], sm[i],
                               64'(av[i]), 64'(bv[i]));
        end
      end
    end
  end

  // every cycle: DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("busy", WS[i], 64'(bz[i]), 64'(m_cnt[i] > 0));
        chk("done", WS[i], 64'(dn[i]), 64'(m_done[i]));
        chk("product", WS[i], pr[i], m_prod[i]);
      end
    end
  end

  task automatic run_op(int i, bit s, longint x,
                        longint y, output int lat,
                        output int bc);
    @(negedge clk);
    st[i] = 1'b1;
    sm[i] = s;
    av[i] = 32'(x);
    bv[i] = 32'(y);
    lat = 0;
    bc = 0;
    do begin
      @(negedge clk);
      st[i] = 1'b0;
      lat++;
      if (bz[i]) bc++;
    end while (!dn[i] && lat < 60);
    chk("timeout", WS[i], 64'(dn[i]), 1);
    chk("latency", WS[i], 64'(lat), 64'(WS[i] + 2));
  endtask

  initial begin
    int lat, bc, gap, nd;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; sm[i] = 1'b0;
      av[i] = '0;   bv[i] = '0;
      m_pend[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", 8, 64'(bz[1]), 0);
    chk("rst_done", 8, 64'(dn[1]), 0);
    chk("rst_prod", 8, pr[1], 0);
    chk("rst_prod16", 16, pr[2], 0);
    reset = 1'b0;
    chk_en = 1'b1;

    run_op(1, 1'b0, 255, 255, lat, bc);
    chk("busy_cycles", 8, 64'(bc), 9);
    chk("u255x255", 8, pr[1], 65025);

    run_op(1, 1'b1, 'h80, 'h80, lat, bc);
    chk("s_m128xm128", 8, pr[1], 16384);
    run_op(1, 1'b1, 'h80, 'h7F, lat, bc);
    chk("s_m128x127", 8, pr[1], 'hC080);
    run_op(1, 1'b1, 'hFF, 'h01, lat, bc);
    chk("s_m1x1", 8, pr[1], 'hFFFF);
    run_op(1, 1'b1, 'h00, 'hB3, lat, bc);
    chk("s_0xm77", 8, pr[1], 0);

    // back-to-back with start held high
    @(negedge clk);
    st[0] = 1'b1; sm[0] = 1'b0; av[0] = 13; bv[0] = 11;
    gap = 0;
    while (!dn[0] && gap < 40) begin
      @(negedge clk); gap++;
    end
    gap = 0;
    do begin
      @(negedge clk); gap++;
    end while (!dn[0] && gap < 40);
    chk("b2b_gap", 4, 64'(gap), 6);
    chk("b2b_prod", 4, pr[0], 143);
    st[0] = 1'b0;
    repeat (10) @(negedge clk);

    // reset during RUN kills the operation
    @(negedge clk);
    st[1] = 1'b1; sm[1] = 1'b0; av[1] = 200; bv[1] = 3;
    @(negedge clk);
    st[1] = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 8, 64'(bz[1]), 0);
    chk("mid_rst_prod", 8, pr[1], 0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (14) begin
      @(negedge clk);
      if (dn[1]) nd++;
    end
    chk("mid_rst_nodone", 8, 64'(nd), 0);
    run_op(1, 1'b0, 6, 7, lat, bc);
    chk("u6x7", 8, pr[1], 42);

    // start while busy is ignored
    @(negedge clk);
    st[1] = 1'b1; sm[1] = 1'b0; av[1] = 37; bv[1] = 91;
    @(negedge clk);
    st[1] = 1'b0;
    repeat (3) @(negedge clk);
    st[1] = 1'b1; av[1] = 5; bv[1] = 5;
    @(negedge clk);
    st[1] = 1'b0;
    gap = 0;
    while (!dn[1] && gap < 40) begin
      @(negedge clk); gap++;
    end
    chk("ign_done", 8, 64'(dn[1]), 1);
    chk("ign_prod", 8, pr[1], 3367);
    repeat (5) @(negedge clk);
    chk("hold_prod", 8, pr[1], 3367);

    // random mixed-mode operations on the 8- and 16-bit units
    for (int n = 0; n < 1000; n++) begin
      int i;
      longint x, y;
      i = (n % 2 == 0) ? 1 : 2;
      x = longint'($urandom);
      y = longint'($urandom);
      case ($urandom_range(0, 7))
        0: x = 64'sd1 <<< (WS[i] - 1);
        1: y = 0;
        2: x = -1;
        default: ;
      endcase
      x = x & ((64'sd1 <<< WS[i]) - 1);
      y = y & ((64'sd1 <<< WS[i]) - 1);
      run_op(i, 1'($urandom_range(0, 1)), x, y, lat, bc);
      chk("rand_prod", WS[i], pr[i],
          ref_mul(WS[i], sm[i], x, y));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
